dcm_supervisor_clken: RTL and testbench

// - Supervises a DCM: drives its reset, qualifies LOCKED and holds a synchronous system reset until the clock is stable.
// - Re-runs the lock sequence when lock is lost, and counts the losses.
// - Generates NCH fractional clock-enable strobes (phase accumulators) from the DCM output clock for downstream cores.
// - Sits directly behind the DCM, on the CLKFX domain; CLK is CLKFX.

---
 rtl/dcm_supervisor_clken_if.sv | 12 +
 rtl/dcm_supervisor_clken.sv | 178 +++++++++++++++++
 tb/tb_dcm_supervisor_clken.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dcm_supervisor_clken_if.sv
// Configuration bus of the DCM supervisor: per-channel phase-increment writes.
// The controller side drives the master modport; the supervisor takes the slave modport.
interface dcm_supervisor_clken_if #(
    parameter int ACC_W = 24
);
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_inc;

    modport master (output cfg_we, output cfg_ch, output cfg_inc);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_inc);
endinterface

// File: rtl/dcm_supervisor_clken.sv
// DCM supervisor: lock qualification, system reset release, lock-loss counting and NCH
// phase-accumulator clock enables. Optional macro DCM_STATUS_MON_EN adds DCM_STATUS fault monitoring.
module dcm_supervisor_clken #(
    parameter int NCH       = 2,
    parameter int ACC_W     = 24,
    parameter int RST_PULSE = 8,
    parameter int LOCK_TMO  = 65535,
    parameter int SETTLE    = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dcm_locked,
    input  logic [7:0]             dcm_status,
    output logic                   dcm_rst,
    output logic                   sys_rst,
    output logic                   ready,
    output logic [7:0]             loss_cnt,
    dcm_supervisor_clken_if.slave  cfg,
    output logic [NCH-1:0]         clken
);

    localparam int TMR_MAX = (LOCK_TMO > SETTLE) ? LOCK_TMO : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(RST_PULSE - 1);
    localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(LOCK_TMO - 1);
    localparam logic [TMR_W-1:0] SETTLE_END = TMR_W'(SETTLE);

    typedef enum logic [1:0] {
        ST_PULSE  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [TMR_W-1:0]   timer_r;
    logic [TMR_W-1:0]   timer_s;
    logic               lk_meta_r;
    logic               lk_r;
    logic               fault_s;
    logic               ok_s;
    logic               dcm_rst_r;
    logic               sys_rst_r;
    logic               ready_r;
    logic [7:0]         loss_cnt_r;
    logic [ACC_W-1:0]   inc_r [NCH];
    logic [ACC_W-1:0]   acc_r [NCH];
    logic [ACC_W:0]     sum_s [NCH];
    logic [NCH-1:0]     clken_r;
    logic               unused_status_s;

    // Two-flop synchroniser for the asynchronous LOCKED input.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_meta_r <= 1'b0;
            lk_r      <= 1'b0;
        end else begin
            lk_meta_r <= dcm_locked;
            lk_r      <= lk_meta_r;
        end
    end

`ifdef DCM_STATUS_MON_EN
    logic [1:0] st_meta_r;
    logic [1:0] st_r;

    // Two-flop synchroniser for the CLKIN-stopped / CLKFX-stopped status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_meta_r <= 2'b00;
            st_r      <= 2'b00;
        end else begin
            st_meta_r <= dcm_status[2:1];
            st_r      <= st_meta_r;
        end
    end

    assign fault_s         = |st_r;
    assign unused_status_s = ^{dcm_status[7:3], dcm_status[0]};
`else
    assign fault_s         = 1'b0;
    assign unused_status_s = ^dcm_status;
`endif

    // A stopped-clock status counts as lock loss once the clock has been qualified.
    assign ok_s = lk_r & ~fault_s;

    // Next-state logic; the shared timer restarts on every state change.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        case (state_r)
            ST_PULSE: begin
                if (timer_r == PULSE_LAST) state_s = ST_WAIT;
                else                       state_s = ST_PULSE;
            end
            ST_WAIT: begin
                if (lk_r)                       state_s = ST_SETTLE;
                else if (timer_r == TMO_LAST)   state_s = ST_PULSE;
                else                            state_s = ST_WAIT;
            end
            ST_SETTLE: begin
                if (!ok_s)                        state_s = ST_WAIT;
                else if (timer_r == SETTLE_END)   state_s = ST_RUN;
                else                              state_s = ST_SETTLE;
            end
            ST_RUN: begin
                if (!ok_s) state_s = ST_PULSE;
                else       state_s = ST_RUN;
            end
            default: state_s = ST_PULSE;
        endcase

        if (state_s != state_r)   timer_s = {TMR_W{1'b0}};
        else if (state_r == ST_RUN) timer_s = {TMR_W{1'b0}};
        else                      timer_s = timer_r + TMR_W'(1);
    end

    // State, timer, registered status outputs and saturating lock-loss counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_PULSE;
            timer_r    <= {TMR_W{1'b0}};
            dcm_rst_r  <= 1'b1;
            sys_rst_r  <= 1'b1;
            ready_r    <= 1'b0;
            loss_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            dcm_rst_r <= (state_s == ST_PULSE);
            sys_rst_r <= (state_s != ST_RUN);
            ready_r   <= (state_s == ST_RUN);
            if ((state_r == ST_RUN) && (state_s != ST_RUN) && (loss_cnt_r != 8'hFF)) begin
                loss_cnt_r <= loss_cnt_r + 8'd1;
            end
        end
    end

    // Per-channel accumulator sum; the extra top bit is the wrap carry.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum_s[i] = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
        end
    end

    // Increment registers survive lock loss; accumulators only run while staying in or entering RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                inc_r[i]   <= {ACC_W{1'b0}};
                acc_r[i]   <= {ACC_W{1'b0}};
                clken_r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg.cfg_we && (cfg.cfg_ch == 3'(i))) begin
                    inc_r[i] <= cfg.cfg_inc;
                end
                if (state_s == ST_RUN) begin
                    acc_r[i]   <= sum_s[i][ACC_W-1:0];
                    clken_r[i] <= sum_s[i][ACC_W];
                end else begin
                    acc_r[i]   <= {ACC_W{1'b0}};
                    clken_r[i] <= 1'b0;
                end
            end
        end
    end

    assign dcm_rst  = dcm_rst_r;
    assign sys_rst  = sys_rst_r;
    assign ready    = ready_r;
    assign loss_cnt = loss_cnt_r;
    assign clken    = clken_r;

endmodule

// File: tb/tb_dcm_supervisor_clken.sv
// Directed bench for dcm_supervisor_clken (ACC_W=8, RST_PULSE=8, LOCK_TMO=100, SETTLE=15).
// Cycle k is the interval after the (k-1)-th clock edge following the last reset edge; sampled at negedge.
module tb_dcm_supervisor_clken;

    logic       clk = 1'b0;
    logic       rst;
    logic       dcm_locked;
    logic [7:0] dcm_status;
    logic       dcm_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] loss_cnt;
    logic [1:0] clken;

    int checks = 0;
    int errors = 0;
    int base   = 0;
    int n0;
    int n1;
    int wt;

    dcm_supervisor_clken_if #(.ACC_W(8)) cfg_if ();

    dcm_supervisor_clken #(
        .NCH(2), .ACC_W(8), .RST_PULSE(8), .LOCK_TMO(100), .SETTLE(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dcm_locked (dcm_locked),
        .dcm_status (dcm_status),
        .dcm_rst    (dcm_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .loss_cnt   (loss_cnt),
        .cfg        (cfg_if),
        .clken      (clken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset(input logic locked);
        @(negedge clk);
        rst        = 1'b1;
        dcm_locked = locked;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [7:0] inc);
        cfg_if.cfg_we  = 1'b1;
        cfg_if.cfg_ch  = ch;
        cfg_if.cfg_inc = inc;
        @(negedge clk);
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic wait_ready();
        wt = 0;
        while (!ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        check("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        dcm_locked     = 1'b0;
        dcm_status     = 8'h00;
        cfg_if.cfg_we  = 1'b0;
        cfg_if.cfg_ch  = 3'd0;
        cfg_if.cfg_inc = 8'd0;

        // Reset values, then LOCKED never high: DCM_RST re-pulses every 108 cycles.
        repeat (3) @(negedge clk);
        check("rst_dcm_rst", {31'd0, dcm_rst}, 32'd1);
        check("rst_sys_rst", {31'd0, sys_rst}, 32'd1);
        check("rst_ready",   {31'd0, ready},   32'd0);
        check("rst_clken",   {30'd0, clken},   32'd0);
        check("rst_loss",    {24'd0, loss_cnt}, 32'd0);
        rst = 1'b0;
        for (int cyc = 1; cyc <= 220; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == 8 || cyc == 109 || cyc == 116 || cyc == 217) begin
                check("tmo_dcm_rst_hi", {31'd0, dcm_rst}, 32'd1);
                check("tmo_sys_rst",    {31'd0, sys_rst}, 32'd1);
            end
            if (cyc == 9 || cyc == 108 || cyc == 117 || cyc == 216) begin
                check("tmo_dcm_rst_lo", {31'd0, dcm_rst}, 32'd0);
                check("tmo_sys_rst",    {31'd0, sys_rst}, 32'd1);
            end
        end
        check("tmo_loss",  {24'd0, loss_cnt}, 32'd0);
        check("tmo_ready", {31'd0, ready},    32'd0);

        // Fastest lock path, config writes during PULSE, then INC=64 / INC=85 strobes.
        apply_reset(1'b1);
        n0 = 0;
        n1 = 0;
        for (int cyc = 1; cyc <= 281; cyc++) begin
            if (cyc > 1) @(negedge clk);
            cfg_if.cfg_we = 1'b0;
            if (cyc == 2) begin
                cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 3'd0; cfg_if.cfg_inc = 8'd64;
            end
            if (cyc == 3) begin
                cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 3'd1; cfg_if.cfg_inc = 8'd85;
            end
            if (cyc == 4) begin
                cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 3'd2; cfg_if.cfg_inc = 8'd255;
            end
            if (cyc == 8) check("fast_dcm_rst_hi", {31'd0, dcm_rst}, 32'd1);
            if (cyc == 9) check("fast_dcm_rst_lo", {31'd0, dcm_rst}, 32'd0);
            if (cyc == 25) begin
                check("fast_ready_25",   {31'd0, ready},   32'd0);
                check("fast_sys_rst_25", {31'd0, sys_rst}, 32'd1);
            end
            if (cyc == 26) begin
                check("fast_ready_26",   {31'd0, ready},   32'd1);
                check("fast_sys_rst_26", {31'd0, sys_rst}, 32'd0);
                check("fast_clken_26",   {30'd0, clken},   32'd0);
            end
            if (cyc >= 26) begin
                check("ch0_inc64_pattern", {31'd0, clken[0]}, ((cyc - 26) % 4 == 3) ? 32'd1 : 32'd0);
                n0 += int'(clken[0]);
                n1 += int'(clken[1]);
            end
        end
        check("ch0_inc64_count", n0, 32'd64);
        check("ch1_inc85_count", n1, 32'd85);

        // INC=0 never strobes; INC=255 gives 255 strobes per 256 cycles.
        cfg_write(3'd0, 8'd0);
        cfg_write(3'd1, 8'd255);
        repeat (2) @(negedge clk);
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            n0 += int'(clken[0]);
            n1 += int'(clken[1]);
        end
        check("ch0_inc0_count",   n0, 32'd0);
        check("ch1_inc255_count", n1, 32'd255);
        cfg_write(3'd0, 8'd64);

        // DCM_STATUS[2] in RUN with LOCKED still high.
        dcm_status = 8'h04;
        repeat (6) @(negedge clk);
        dcm_status = 8'h00;
`ifdef DCM_STATUS_MON_EN
        check("status_sys_rst", {31'd0, sys_rst}, 32'd1);
        check("status_loss",    {24'd0, loss_cnt}, 32'd1);
        base = 1;
        wait_ready();
`else
        check("status_ready", {31'd0, ready},    32'd1);
        check("status_loss",  {24'd0, loss_cnt}, 32'd0);
        base = 0;
`endif

        // 300 lock drops: reset within 3 cycles, saturating count, ACC cleared, INC retained.
        for (int i = 0; i < 300; i++) begin
            dcm_locked = 1'b0;
            @(negedge clk);
            dcm_locked = 1'b1;
            repeat (2) @(negedge clk);
            check("drop_sys_rst", {31'd0, sys_rst}, 32'd1);
            check("drop_ready",   {31'd0, ready},   32'd0);
            check("drop_clken",   {30'd0, clken},   32'd0);
            check("drop_loss",    {24'd0, loss_cnt}, (base + i + 1 > 255) ? 32'd255 : 32'(base + i + 1));
            wait_ready();
            check("relock_clken_1", {30'd0, clken}, 32'd0);
            @(negedge clk);
            check("relock_clken_2", {30'd0, clken}, 32'd2);
            @(negedge clk);
            check("relock_clken_3", {30'd0, clken}, 32'd2);
            @(negedge clk);
            check("relock_clken_4", {30'd0, clken}, 32'd3);
        end
        check("loss_saturated", {24'd0, loss_cnt}, 32'd255);

        // One-cycle LOCKED glitch when the SETTLE count is 10 restarts the settle window.
        apply_reset(1'b1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (cyc == 18) dcm_locked = 1'b0;
            if (cyc == 19) dcm_locked = 1'b1;
            if (cyc == 26) check("glitch_ready_26", {31'd0, ready}, 32'd0);
            if (cyc == 37) check("glitch_ready_37", {31'd0, ready}, 32'd0);
            if (cyc == 38) begin
                check("glitch_ready_38",   {31'd0, ready},   32'd1);
                check("glitch_sys_rst_38", {31'd0, sys_rst}, 32'd0);
            end
        end
        check("glitch_loss", {24'd0, loss_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
